// File: rtl/voice_osc.sv
// Tone voice stage: square wave at period cyc with an exponentially decaying
// envelope, retriggered by attack. The output sample is signed 16-bit.
module voice_osc #(
    parameter logic [14:0] PEAK        = 15'h7FFF,
    parameter int          DECAY_DIV   = 4096,
    parameter int          DECAY_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        cyc,
    input  logic               attack,
    output logic signed [15:0] sample,
    output logic               active
);

    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        REST = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        per_q_reg, per_q_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [14:0]        amp_reg, amp_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [15:0]        sample_reg, sample_next;
    logic               active_reg, active_next;

    logic               phase_high;
    logic               div_wrap;
    logic [14:0]        step;

    // State register; reset acts immediately, even in the middle of a note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            per_q_reg  <= 16'd0;
            cnt_reg    <= 16'd0;
            amp_reg    <= 15'd0;
            div_reg    <= '0;
            sample_reg <= 16'd0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            per_q_reg  <= per_q_next;
            cnt_reg    <= cnt_next;
            amp_reg    <= amp_next;
            div_reg    <= div_next;
            sample_reg <= sample_next;
            active_reg <= active_next;
        end
    end

    // Next-state: attack overrides everything; otherwise only PLAY evolves.
    always_comb begin
        state_next = state_reg;
        per_q_next = per_q_reg;
        cnt_next   = cnt_reg;
        amp_next   = amp_reg;
        div_next   = div_reg;

        phase_high = (cnt_reg < (per_q_reg >> 1));
        div_wrap   = (div_reg == DIV_LAST);
        // Small amplitudes would shift to zero; force at least one LSB so
        // the envelope always reaches silence.
        step       = amp_reg >> DECAY_SHIFT;
        if (step == 15'd0) begin
            step = 15'd1;
        end

        if (attack) begin
            per_q_next = cyc;
            cnt_next   = 16'd0;
            div_next   = '0;
            if (cyc >= 16'd2) begin
                amp_next   = PEAK;
                state_next = PLAY;
            end else begin
                amp_next   = 15'd0;
                state_next = REST;
            end
        end else if (state_reg == PLAY) begin
            if (cnt_reg == per_q_reg - 16'd1) begin
                cnt_next = 16'd0;
            end else begin
                cnt_next = cnt_reg + 16'd1;
            end
            if (div_wrap) begin
                div_next = '0;
                if (amp_reg <= step) begin
                    amp_next   = 15'd0;
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    amp_next = amp_reg - step;
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    // Output sample and active flag, registered from the current-cycle state.
    always_comb begin
        sample_next = 16'd0;
        active_next = (state_reg == PLAY);
        if (state_reg == PLAY) begin
            if (phase_high) begin
                sample_next = {1'b0, amp_reg};
            end else begin
                sample_next = 16'd0 - {1'b0, amp_reg};
            end
        end
    end

    assign sample = $signed(sample_reg);
    assign active = active_reg;

endmodule

// File: tb/tb_voice_osc.sv
// Scoreboard bench for voice_osc: expected samples are derived in closed form
// from time since the last attack, queued, then popped once per clock.
module tb_voice_osc;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [15:0]        cyc = 16'd0;
    logic               attack = 1'b0;
    logic signed [15:0] sample_main, sample_fast;
    logic               active_main, active_fast;

    typedef struct {
        logic [15:0] sample;
        logic        active;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    voice_osc u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .cyc    (cyc),
        .attack (attack),
        .sample (sample_main),
        .active (active_main)
    );

    voice_osc #(.DECAY_DIV(2), .DECAY_SHIFT(4)) u_fast (
        .clk    (clk),
        .rst_n  (rst_n),
        .cyc    (cyc),
        .attack (attack),
        .sample (sample_fast),
        .active (active_fast)
    );

    always #5 clk = ~clk;

    // Envelope after m decay steps starting from full scale.
    function automatic logic [14:0] exp_amp(input int m);
        logic [14:0] a;
        logic [14:0] st;
        a = 15'h7FFF;
        for (int i = 0; i < m; i++) begin
            st = a >> 4;
            if (st == 15'd0) st = 15'd1;
            if (a <= st) a = 15'd0;
            else a = a - st;
        end
        return a;
    endfunction

    // Expected output k clocks after the attack edge (p<2 means rest/idle).
    function automatic exp_t exp_at(input int p, input int d, input int k);
        exp_t        e;
        logic [14:0] a;
        e.sample = 16'd0;
        e.active = 1'b0;
        if (p >= 2) begin
            a = exp_amp((k - 1) / d);
            if (a != 15'd0) begin
                e.active = 1'b1;
                if (((k - 1) % p) < (p / 2)) e.sample = {1'b0, a};
                else e.sample = 16'd0 - {1'b0, a};
            end
        end
        return e;
    endfunction

    // Drive attack for 'hold' edges; returns at the negedge after the last one.
    task automatic do_attack(input logic [15:0] c, input int hold);
        @(negedge clk);
        cyc    = c;
        attack = 1'b1;
        repeat (hold) @(negedge clk);
        attack = 1'b0;
    endtask

    // Queue n expected cycles, then pop and compare one per clock.
    task automatic check_window(input int inst, input int p, input int d,
                                input int n, input string name);
        exp_t        e;
        logic [15:0] s;
        logic        a;
        for (int k = 1; k <= n; k++) sb_q.push_back(exp_at(p, d, k));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            s = (inst == 0) ? sample_main : sample_fast;
            a = (inst == 0) ? active_main : active_fast;
            checks++;
            if (s !== e.sample || a !== e.active) begin
                errors++;
                $display("FAIL %s k=%0d got sample=%0d active=%b want sample=%0d active=%b",
                         name, k, $signed(s), a, $signed(e.sample), e.active);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample_main !== 16'sd0 || active_main !== 1'b0 ||
            sample_fast !== 16'sd0 || active_fast !== 1'b0) begin
            errors++;
            $display("FAIL reset got %0d/%b %0d/%b want 0/0 0/0",
                     sample_main, active_main, sample_fast, active_fast);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_window(0, 0, 4096, 1000, "idle");
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_square8();
        do_attack(16'd8, 1);
        check_window(0, 8, 4096, 40, "square8");
        $display("test_square8 done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_odd7_decay();
        do_attack(16'd7, 1);
        check_window(0, 7, 4096, 4110, "odd7");
        $display("test_odd7_decay done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_rest();
        do_attack(16'd8, 1);
        check_window(0, 8, 4096, 10, "pre_rest");
        do_attack(16'd1, 1);
        check_window(0, 1, 4096, 10, "rest");
        do_attack(16'd10, 1);
        check_window(0, 10, 4096, 25, "restart10");
        $display("test_rest done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        do_attack(16'd8, 3);
        cyc = 16'd3;  // must be ignored outside attack
        check_window(0, 8, 4096, 20, "retrigger");
        $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fast_decay();
        do_attack(16'd8, 1);
        check_window(1, 8, 2, 400, "fast_decay");
        $display("test_fast_decay done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_async_reset();
        do_attack(16'd8, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample_main !== 16'sd0 || active_main !== 1'b0 ||
            sample_fast !== 16'sd0 || active_fast !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %0d/%b %0d/%b want 0/0 0/0",
                     sample_main, active_main, sample_fast, active_fast);
        end
        #1 rst_n = 1'b1;
        check_window(0, 0, 4096, 20, "post_reset_main");
        check_window(1, 0, 2, 20, "post_reset_fast");
        $display("test_async_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_square8();
        test_odd7_decay();
        test_rest();
        test_back_to_back();
        test_fast_decay();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
